// File: rtl/alu_accum_sequencer_if.sv
// Command, result and alu-facing signals of the accumulator sequencer.
// slave is the sequencer's view; master is the surrounding system's view.
interface alu_accum_sequencer_if #(
  parameter int WIDTH  = 4,
  parameter int FLAG_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_load;
  logic [2:0]        cmd_opcode;
  logic [WIDTH-1:0]  cmd_operand;
  logic [WIDTH-1:0]  alu_in1;
  logic [WIDTH-1:0]  alu_in2;
  logic [2:0]        alu_opcode;
  logic [WIDTH-1:0]  alu_out;
  logic [FLAG_W-1:0] alu_flags;
  logic              res_valid;
  logic              res_ready;
  logic [WIDTH-1:0]  res_data;
  logic [FLAG_W-1:0] res_flags;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_load, cmd_opcode, cmd_operand, alu_out, alu_flags, res_ready,
    output cmd_ready, alu_in1, alu_in2, alu_opcode, res_valid, res_data, res_flags, busy
  );

  modport master (
    output cmd_valid, cmd_load, cmd_opcode, cmd_operand, alu_out, alu_flags, res_ready,
    input  cmd_ready, alu_in1, alu_in2, alu_opcode, res_valid, res_data, res_flags, busy
  );
endinterface

// File: rtl/alu_accum_sequencer.sv
// Clocked accumulator around an external combinational alu: accepts a command,
// holds the alu inputs for SETTLE_CYCLES, captures the result and hands it downstream.
module alu_accum_sequencer #(
  parameter int WIDTH         = 4,
  parameter int FLAG_W        = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_accum_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESULT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  in2_q;
  logic [2:0]        opc_q;
  logic [WIDTH-1:0]  rdata_q;
  logic [FLAG_W-1:0] rflags_q;

  // Loads bypass the alu, so only sign and zero can be meaningful: bit3 negative, bit2 zero.
  function automatic logic [FLAG_W-1:0] load_flags(input logic [WIDTH-1:0] v);
    logic [FLAG_W-1:0] f;
    f    = '0;
    f[3] = v[WIDTH-1];
    f[2] = (v == '0);
    return f;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      in2_q    <= '0;
      opc_q    <= '0;
      rdata_q  <= '0;
      rflags_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_load) begin
              acc_q    <= bus.cmd_operand;
              rdata_q  <= bus.cmd_operand;
              rflags_q <= load_flags(bus.cmd_operand);
              state_q  <= RESULT;
            end else begin
              in2_q   <= bus.cmd_operand;
              opc_q   <= bus.cmd_opcode;
              cnt_q   <= CNT_INIT;
              state_q <= DRIVE;
            end
          end
        end
        DRIVE: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            acc_q    <= bus.alu_out;
            rdata_q  <= bus.alu_out;
            rflags_q <= bus.alu_flags;
            state_q  <= RESULT;
          end
        end
        RESULT: begin
          if (bus.res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The handshake and status outputs decode state directly so they track reset immediately.
  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.res_valid  = (state_q == RESULT);
  assign bus.busy       = (state_q != IDLE);
  assign bus.alu_in1    = acc_q;
  assign bus.alu_in2    = in2_q;
  assign bus.alu_opcode = opc_q;
  assign bus.res_data   = rdata_q;
  assign bus.res_flags  = rflags_q;

endmodule
